axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- Simulation-side AXI4 slave that answers the core's m_axi_* master port.
- Backs a word-addressed 64-bit memory array and serves one read burst and one write burst concurrently.
- Sits in the sim top between the core wrapper and the testbench memory loader, which fills the array through the backdoor port.
- Supports FIXED, INCR and WRAP bursts, narrow transfers and error responses for unmapped addresses.

Parameters:
- IDW, 8, AXI ID width.
- MEM_BASE, 64'h80000000, first byte address of backing memory.
- MEM_WORDS, 65536, number of 64-bit words (power of two).
- CLINT, 64'h2000000, CLINT base; mtime lives at CLINT+64'hbff8.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  IDW/64/8/3/2/1  write address channel
- s_axi_awready  out  1  write address ready
- s_axi_wdata/wstrb/wlast/wvalid  in  64/8/1/1  write data channel
- s_axi_wready  out  1  write data ready
- s_axi_bid/bresp/bvalid  out  IDW/2/1  write response channel
- s_axi_bready  in  1  write response ready
- s_axi_arid/araddr/arlen/arsize/arburst/arvalid  in  IDW/64/8/3/2/1  read address channel
- s_axi_arready  out  1  read address ready
- s_axi_rid/rdata/rresp/rlast/rvalid  out  IDW/64/2/1/1  read data channel
- s_axi_rready  in  1  read data ready
- bd_we  in  1  backdoor write enable
- bd_addr  in  64  backdoor byte address (8-aligned)
- bd_wdata  in  64  backdoor write data
- mtime  in  64  CLINT time value (used only with the optional feature)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All valid/ready outputs are 0; bid, bresp, rid, rresp, rlast and rdata are 0; both FSMs go to IDLE.
  - Memory contents are not cleared.
- Reset mid-burst: the burst is abandoned with no B or R beat. Writes already accepted stay in memory.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size and burst, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the lanes enabled by wstrb to word (addr-MEM_BASE)>>3, then advances the address.
  - W_DATA exit: on the beat where wlast=1, or when len+1 beats have been taken, go to W_RESP.
  - wlast mismatch: if wlast arrives early or late relative to len, bresp=SLVERR (2'b10).
  - W_RESP: bvalid=1 and held until bready, then return to W_IDLE.
  - awready is 0 outside W_IDLE; at most one write is outstanding.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch the request; rvalid rises the next cycle.
  - R_DATA: rdata is a registered read of the current address.
  - On R handshake, advance the address and load the next beat, so a continuously ready master sees 1 beat per cycle.
  - rlast=1 on beat len. After its handshake, return to R_IDLE.
  - rvalid, rdata, rresp and rlast are stable while rvalid=1 and rready=0.
- Address advance, with step = 1<<size:
  - FIXED (0): address unchanged.
  - INCR (1): addr += step.
  - WRAP (2): addr = (addr & ~mask) | ((addr+step) & mask), where mask = ((len+1)<<size)-1.
  - Reserved (3): treated as INCR, with every response SLVERR.
- Narrow transfers: rdata carries the full 64-bit word and the master selects lanes. Writes rely on wstrb only.
- Decode:
  - addr in [MEM_BASE, MEM_BASE+8*MEM_WORDS) gives OKAY (2'b00).
  - Any other address gives DECERR (2'b11): writes are dropped and reads return 0.
  - Decode is evaluated per beat, so a burst crossing the top of memory errors only on the beats beyond it.
- Concurrency:
  - AR and AW may handshake in the same cycle.
  - A write beat and a read load to the same word in the same cycle: the read returns the pre-write data.
  - Backdoor priority: bd_we writes the whole word. If it collides with a W beat to the same word, the W beat wins.

Optional Feature:
- Macro: CLINT_MTIME_EN.
- Defined: a read beat whose address is CLINT+64'hbff8 returns the mtime input sampled on that beat's load cycle, with OKAY. Writes to that address are dropped with OKAY.
- Undefined: CLINT+64'hbff8 is unmapped (DECERR, rdata 0), and the mtime input is ignored.

Test Plan:
- Single beat, bd-preloaded data:
  - Stimulus: backdoor 64'h1122334455667788 at 0x80000008; AR addr 0x80000008, len 0, size 3, INCR, rready=1.
  - Response: one R beat with that data, rresp 0, rlast 1, arriving 1 cycle after the AR handshake.
- WRAP burst:
  - Stimulus: AR addr 0x80000018, len 3, size 3, WRAP.
  - Response: beats read words at 0x18, 0x00, 0x08, 0x10; rlast only on the 4th beat.
- Narrow write:
  - Stimulus: AW 0x80000004, len 0, size 2; wstrb 8'hF0, wdata 64'hAABBCCDD_00000000; then read back 0x80000000.
  - Response: upper 32 bits AABBCCDD, lower bits unchanged, bresp 0.
- Decode error and backpressure:
  - Stimulus: AR 0x00001000, len 1; hold rready=0 for 3 cycles.
  - Response: rvalid stays 1 with rdata 0 and rresp 2'b11, stable across the stall; 2 beats total.
- Reset mid-burst:
  - Stimulus: start an INCR write, len 7; assert rst after beat 3.
  - Response: next cycle bvalid=0, wready=0, awready=0. Words 0-2 hold the new data, words 3-7 hold the old data.
- CLINT_MTIME_EN:
  - Stimulus: mtime=64'd12345; AR 0x200bff8.
  - Response: rdata 12345, rresp 0. With the macro undefined: rdata 0, rresp 2'b11.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 slave over a word-addressed 64-bit memory with a backdoor load port; one read and one write burst in flight.
// Optional feature macro CLINT_MTIME_EN maps CLINT+0xbff8 as a read-only mtime location.
module axi_mem_responder #(
  parameter int          IDW       = 8,
  parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
  parameter int          MEM_WORDS = 65536,
  parameter logic [63:0] CLINT     = 64'h200_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDW-1:0] s_axi_awid,
  input  logic [63:0]    s_axi_awaddr,
  input  logic [7:0]     s_axi_awlen,
  input  logic [2:0]     s_axi_awsize,
  input  logic [1:0]     s_axi_awburst,
  input  logic           s_axi_awvalid,
  output logic           s_axi_awready,
  input  logic [63:0]    s_axi_wdata,
  input  logic [7:0]     s_axi_wstrb,
  input  logic           s_axi_wlast,
  input  logic           s_axi_wvalid,
  output logic           s_axi_wready,
  output logic [IDW-1:0] s_axi_bid,
  output logic [1:0]     s_axi_bresp,
  output logic           s_axi_bvalid,
  input  logic           s_axi_bready,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic [63:0]    s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [IDW-1:0] s_axi_rid,
  output logic [63:0]    s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  input  logic           bd_we,
  input  logic [63:0]    bd_addr,
  input  logic [63:0]    bd_wdata,
  input  logic [63:0]    mtime
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [63:0] MEM_END    = MEM_BASE + 64'(MEM_WORDS) * 64'd8;
  localparam logic [63:0] MTIME_ADDR = CLINT + 64'hbff8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] mask;
    step = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:     next_addr = addr + step;
    endcase
  endfunction

  function automatic logic in_mem(input logic [63:0] addr);
    in_mem = (addr >= MEM_BASE) && (addr < MEM_END);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [63:0] addr);
    logic [63:0] off;
    off = (addr - MEM_BASE) >> 3;
    word_idx = off[AW-1:0];
  endfunction

  logic [63:0] mem [MEM_WORDS];

  // ---------------- write path ----------------
  logic [1:0]  w_state;
  logic [63:0] w_addr;
  logic [7:0]  w_len;
  logic [7:0]  w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_slv;
  logic        w_dec;

  logic        aw_fire;
  logic        w_fire;
  logic        w_hit;
  logic        w_miss;
  logic        w_at_len;
  logic        w_done;
  logic        w_mismatch;
  logic [1:0]  w_final_resp;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] bd_idx;

  assign aw_fire    = s_axi_awvalid && s_axi_awready;
  assign w_fire     = s_axi_wvalid && s_axi_wready;
  assign w_hit      = in_mem(w_addr);
`ifdef CLINT_MTIME_EN
  assign w_miss     = !w_hit && (w_addr != MTIME_ADDR);
`else
  assign w_miss     = !w_hit;
`endif
  assign w_at_len   = (w_cnt == w_len);
  assign w_done     = s_axi_wlast || w_at_len;
  assign w_mismatch = s_axi_wlast != w_at_len;
  assign w_idx      = word_idx(w_addr);
  assign bd_idx     = word_idx(bd_addr);

  always_comb begin
    w_final_resp = RESP_OKAY;
    if (w_slv || w_mismatch)
      w_final_resp = RESP_SLVERR;
    else if (w_dec || w_miss)
      w_final_resp = RESP_DECERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_slv         <= 1'b0;
      w_dec         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_slv         <= (s_axi_awburst == BURST_RSVD);
            w_dec         <= 1'b0;
            s_axi_bid     <= s_axi_awid;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            w_dec  <= w_dec | w_miss;
            // Burst ends on wlast or on the len-th beat, whichever comes first.
            if (w_done) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= w_final_resp;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Backdoor first so a colliding W beat overrides it on its enabled lanes.
  always_ff @(posedge clk) begin
    if (bd_we && in_mem(bd_addr))
      mem[bd_idx] <= bd_wdata;
    if (!rst && w_fire && w_hit) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i])
          mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic [0:0]  r_state;
  logic [63:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;

  logic        ar_fire;
  logic        r_fire;
  logic [63:0] ld_addr;
  logic [1:0]  ld_burst;
  logic [63:0] ld_data;
  logic [1:0]  ld_resp;
  logic [AW-1:0] ld_idx;

  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_fire  = s_axi_rvalid && s_axi_rready;

  // The load address is the request itself when idle, otherwise the next beat.
  always_comb begin
    ld_addr  = next_addr(r_addr, r_len, r_size, r_burst);
    ld_burst = r_burst;
    if (r_state == R_IDLE) begin
      ld_addr  = s_axi_araddr;
      ld_burst = s_axi_arburst;
    end
  end

  assign ld_idx = word_idx(ld_addr);

`ifndef CLINT_MTIME_EN
  logic unused_mtime;
  assign unused_mtime = ^mtime;
`endif

  always_comb begin
    ld_data = '0;
    ld_resp = RESP_OKAY;
    if (in_mem(ld_addr))
      ld_data = mem[ld_idx];
`ifdef CLINT_MTIME_EN
    else if (ld_addr == MTIME_ADDR)
      ld_data = mtime;
`endif
    else
      ld_resp = RESP_DECERR;
    if (ld_burst == BURST_RSVD)
      ld_resp = RESP_SLVERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      s_axi_rlast   <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            s_axi_rid     <= s_axi_arid;
            s_axi_rdata   <= ld_data;
            s_axi_rresp   <= ld_resp;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= ld_addr;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rdata <= ld_data;
              s_axi_rresp <= ld_resp;
              s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: directed scenarios plus randomized bursts against a memory model.
module tb_axi_mem_responder;
  localparam int          IDW     = 8;
  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam int          WORDS   = 65536;
  localparam logic [63:0] MEND    = BASE + 64'(WORDS) * 64'd8;
  localparam logic [63:0] MTIME_A = 64'h200_bff8;

  logic clk = 1'b0;
  logic rst;
  logic [IDW-1:0] awid;   logic [63:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0] awburst;    logic awvalid, awready;
  logic [63:0] wdata;     logic [7:0] wstrb; logic wlast, wvalid, wready;
  logic [IDW-1:0] bid;    logic [1:0] bresp; logic bvalid, bready;
  logic [IDW-1:0] arid;   logic [63:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0] arburst;    logic arvalid, arready;
  logic [IDW-1:0] rid;    logic [63:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic bd_we;            logic [63:0] bd_addr, bd_wdata, mtime;

  axi_mem_responder #(.IDW(IDW), .MEM_BASE(BASE), .MEM_WORDS(WORDS), .CLINT(64'h200_0000)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .mtime(mtime)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0]    model   [WORDS];
  logic [63:0]    wd      [256];
  logic [7:0]     ws      [256];
  logic [63:0]    rd_data [256];
  logic [1:0]     rd_resp [256];
  logic           rd_last [256];
  logic [IDW-1:0] rd_id   [256];

  // ---------------- reference model ----------------
  function automatic logic [63:0] beat_addr(input logic [63:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [63:0] step, total, blk;
    step  = 64'd1 << size;
    total = (64'(len) + 64'd1) * step;
    if (burst == 2'd0) return start;
    if (burst == 2'd2) begin
      blk = start - (start % total);
      return blk + ((start - blk + 64'(i) * step) % total);
    end
    return start + 64'(i) * step;
  endfunction

  function automatic bit mapped(input logic [63:0] a);
    return (a >= BASE) && (a < MEND);
  endfunction

  function automatic logic [63:0] exp_rdata(input logic [63:0] a);
    if (mapped(a)) return model[(a - BASE) >> 3];
`ifdef CLINT_MTIME_EN
    if (a == MTIME_A) return mtime;
`endif
    return 64'd0;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [63:0] a, input logic [1:0] burst);
    if (burst == 2'd3) return 2'b10;
    if (mapped(a)) return 2'b00;
`ifdef CLINT_MTIME_EN
    if (a == MTIME_A) return 2'b00;
`endif
    return 2'b11;
  endfunction

  task automatic model_write(input logic [63:0] start, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int nbeats);
    logic [63:0] a;
    for (int b = 0; b < nbeats; b++) begin
      a = beat_addr(start, len, size, burst, b);
      if (mapped(a))
        for (int l = 0; l < 8; l++)
          if (ws[b][l]) model[(a - BASE) >> 3][8*l +: 8] = wd[b][8*l +: 8];
    end
  endtask

  // ---------------- bus drivers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bd_write(input logic [63:0] a, input logic [63:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    tick();
    bd_we = 1'b0;
    model[(a - BASE) >> 3] = d;
  endtask

  task automatic drive_write(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [IDW-1:0] id, input int nbeats,
                             input int last_at, output logic [1:0] resp, output logic [IDW-1:0] gid,
                             output bit tmo);
    int n;
    tmo = 0;
    awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) tmo = 1;
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick(); end
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_at); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (!wready) tmo = 1;
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) tmo = 1;
    resp = bresp; gid = bid;
    tick();
    bready = 1'b0;
  endtask

  task automatic drive_read(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [IDW-1:0] id, input bit bp,
                            output int nb, output bit tmo);
    int n;
    tmo = 0;
    araddr = a; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) tmo = 1;
    tick();
    arvalid = 1'b0;
    nb = 0; n = 0;
    while (nb <= int'(len) && n < 2000) begin
      rready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rvalid && rready) begin
        rd_data[nb] = rdata; rd_resp[nb] = rresp; rd_last[nb] = rlast; rd_id[nb] = rid;
        nb++;
      end
      tick(); n++;
    end
    if (nb <= int'(len)) tmo = 1;
    rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b want 00000", {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if ({bid, bresp, rid, rresp, rlast} !== '0) begin
      errors++; $display("FAIL reset_ids: bid=%h bresp=%b rid=%h rresp=%b rlast=%b want all 0", bid, bresp, rid, rresp, rlast);
    end
    checks++;
    if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({awready, arready} !== 2'b11) begin
      errors++; $display("FAIL idle_ready: got %b want 11", {awready, arready});
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) bd_write(BASE + 64'(i) * 8, {$urandom, $urandom});
    for (int i = WORDS - 8; i < WORDS; i++) bd_write(BASE + 64'(i) * 8, {$urandom, $urandom});
  endtask

  task automatic test_single_beat();
    int n;
    bd_write(64'h8000_0008, 64'h1122334455667788);
    araddr = 64'h8000_0008; arlen = 0; arsize = 3; arburst = 1; arid = 8'h3C; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL single_latency: rvalid=%b want 1", rvalid); end
    checks++;
    if ({rdata, rresp, rlast, rid} !== {64'h1122334455667788, 2'b00, 1'b1, 8'h3C}) begin
      errors++; $display("FAIL single_beat: rdata=%h rresp=%b rlast=%b rid=%h want 1122334455667788/00/1/3c", rdata, rresp, rlast, rid);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL single_end: rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_wrap();
    int nb; bit tmo;
    int order [4] = '{3, 0, 1, 2};
    drive_read(64'h8000_0018, 8'd3, 3'd3, 2'd2, 8'h11, 1'b1, nb, tmo);
    checks++;
    if (tmo || nb != 4) begin errors++; $display("FAIL wrap_count: beats=%0d tmo=%0d want 4/0", nb, tmo); end
    for (int b = 0; b < 4 && b < nb; b++) begin
      checks++;
      if ({rd_data[b], rd_resp[b], rd_last[b]} !== {model[order[b]], 2'b00, b == 3}) begin
        errors++; $display("FAIL wrap_beat%0d: data=%h resp=%b last=%b want %h/00/%0d", b, rd_data[b], rd_resp[b], rd_last[b], model[order[b]], b == 3);
      end
    end
  endtask

  task automatic test_narrow_write();
    logic [63:0] old; logic [1:0] resp; logic [IDW-1:0] gid; bit tmo; int nb;
    old = model[0];
    wd[0] = 64'hAABBCCDD_00000000; ws[0] = 8'hF0;
    drive_write(64'h8000_0004, 8'd0, 3'd2, 2'd1, 8'h42, 1, 0, resp, gid, tmo);
    checks++;
    if (tmo || resp !== 2'b00 || gid !== 8'h42) begin
      errors++; $display("FAIL narrow_bresp: resp=%b bid=%h tmo=%0d want 00/42/0", resp, gid, tmo);
    end
    model[0] = {32'hAABBCCDD, old[31:0]};
    drive_read(64'h8000_0000, 8'd0, 3'd3, 2'd1, 8'h01, 1'b0, nb, tmo);
    checks++;
    if (tmo || rd_data[0] !== {32'hAABBCCDD, old[31:0]}) begin
      errors++; $display("FAIL narrow_readback: got %h want %h", rd_data[0], {32'hAABBCCDD, old[31:0]});
    end
  endtask

  task automatic test_decerr_backpressure();
    int n;
    araddr = 64'h1000; arlen = 1; arsize = 3; arburst = 1; arid = 8'h5A; rready = 1'b0; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({rvalid, rdata, rresp, rlast} !== {1'b1, 64'd0, 2'b11, 1'b0}) begin
        errors++; $display("FAIL decerr_stall%0d: rvalid=%b rdata=%h rresp=%b rlast=%b want 1/0/11/0", c, rvalid, rdata, rresp, rlast);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    checks++;
    if ({rvalid, rdata, rresp, rlast} !== {1'b1, 64'd0, 2'b11, 1'b1}) begin
      errors++; $display("FAIL decerr_beat1: rvalid=%b rdata=%h rresp=%b rlast=%b want 1/0/11/1", rvalid, rdata, rresp, rlast);
    end
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL decerr_count: rvalid=%b after 2 beats want 0", rvalid); end
  endtask

  task automatic test_random_bursts();
    logic [63:0] start, ea; logic [7:0] len; logic [2:0] size; logic [1:0] burst, resp;
    logic [IDW-1:0] id, gid; bit tmo; int nb;
    for (int it = 0; it < 20; it++) begin
      burst = 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 3));
      len   = (burst == 2'd2) ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 7));
      start = BASE + 64'($urandom_range(0, 40)) * 8 + (64'($urandom_range(0, 7)) & ~((64'd1 << size) - 64'd1));
      id    = IDW'($urandom);
      for (int b = 0; b <= int'(len); b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
      drive_write(start, len, size, burst, id, int'(len) + 1, int'(len), resp, gid, tmo);
      checks++;
      if (tmo || resp !== 2'b00 || gid !== id) begin
        errors++; $display("FAIL rand%0d_bresp: resp=%b bid=%h tmo=%0d want 00/%h/0", it, resp, gid, tmo, id);
      end
      model_write(start, len, size, burst, int'(len) + 1);
      drive_read(start, len, size, burst, ~id, 1'b1, nb, tmo);
      checks++;
      if (tmo || nb != int'(len) + 1) begin
        errors++; $display("FAIL rand%0d_count: beats=%0d want %0d", it, nb, int'(len) + 1);
      end
      for (int b = 0; b < nb; b++) begin
        ea = beat_addr(start, len, size, burst, b);
        checks++;
        if ({rd_data[b], rd_resp[b], rd_last[b], rd_id[b]} !== {exp_rdata(ea), 2'b00, b == int'(len), ~id}) begin
          errors++; $display("FAIL rand%0d_beat%0d: data=%h resp=%b last=%b id=%h want %h/00/%0d/%h", it, b, rd_data[b], rd_resp[b], rd_last[b], rd_id[b], exp_rdata(ea), b == int'(len), ~id);
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [63:0] ea; logic [1:0] resp; logic [IDW-1:0] gid; bit tmo; int nb;
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    drive_write(MEND - 16, 8'd3, 3'd3, 2'd1, 8'h21, 4, 3, resp, gid, tmo);
    model_write(MEND - 16, 8'd3, 3'd3, 2'd1, 4);
    drive_read(MEND - 16, 8'd3, 3'd3, 2'd1, 8'h22, 1'b0, nb, tmo);
    checks++;
    if (tmo || nb != 4) begin errors++; $display("FAIL cross_count: beats=%0d want 4", nb); end
    for (int b = 0; b < nb; b++) begin
      ea = beat_addr(MEND - 16, 8'd3, 3'd3, 2'd1, b);
      checks++;
      if ({rd_data[b], rd_resp[b]} !== {exp_rdata(ea), exp_rresp(ea, 2'd1)}) begin
        errors++; $display("FAIL cross_beat%0d: data=%h resp=%b want %h/%b", b, rd_data[b], rd_resp[b], exp_rdata(ea), exp_rresp(ea, 2'd1));
      end
    end
    drive_read(BASE + 80, 8'd1, 3'd3, 2'd3, 8'h23, 1'b0, nb, tmo);
    for (int b = 0; b < nb; b++) begin
      checks++;
      if ({rd_data[b], rd_resp[b]} !== {model[10 + b], 2'b10}) begin
        errors++; $display("FAIL rsvd_beat%0d: data=%h resp=%b want %h/10", b, rd_data[b], rd_resp[b], model[10 + b]);
      end
    end
  endtask

  task automatic test_wlast_mismatch();
    logic [1:0] resp; logic [IDW-1:0] gid; bit tmo; int nb;
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    drive_write(BASE + 160, 8'd3, 3'd3, 2'd1, 8'h31, 2, 1, resp, gid, tmo);
    checks++;
    if (tmo || resp !== 2'b10) begin errors++; $display("FAIL wlast_early: resp=%b tmo=%0d want 10/0", resp, tmo); end
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL wlast_early_idle: awready=%b want 1", awready); end
    model_write(BASE + 160, 8'd3, 3'd3, 2'd1, 2);
    drive_read(BASE + 160, 8'd3, 3'd3, 2'd1, 8'h32, 1'b0, nb, tmo);
    for (int b = 0; b < nb; b++) begin
      checks++;
      if (rd_data[b] !== model[20 + b]) begin
        errors++; $display("FAIL wlast_early_mem%0d: got %h want %h", b, rd_data[b], model[20 + b]);
      end
    end
    drive_write(BASE + 192, 8'd1, 3'd3, 2'd1, 8'h33, 2, -1, resp, gid, tmo);
    checks++;
    if (tmo || resp !== 2'b10) begin errors++; $display("FAIL wlast_late: resp=%b tmo=%0d want 10/0", resp, tmo); end
  endtask

  task automatic test_concurrent();
    logic [1:0] cresp; bit tmo; int nb, n;
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    awaddr = BASE; awlen = 3; awsize = 3; awburst = 1; awid = 8'h0B; awvalid = 1'b1;
    araddr = BASE + 256; arlen = 3; arsize = 3; arburst = 1; arid = 8'h16; arvalid = 1'b1;
    n = 0;
    while (!(awready && arready) && n < 50) begin tick(); n++; end
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if ({awready, arready, wready, rvalid} !== 4'b0011) begin
      errors++; $display("FAIL dual_accept: aw/ar/w/r ready-valid=%b want 0011", {awready, arready, wready, rvalid});
    end
    nb = 0;
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          wdata = wd[b]; wstrb = ws[b]; wlast = (b == 3); wvalid = 1'b1;
          for (int k = 0; k < 50 && !wready; k++) tick();
          tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        for (int k = 0; k < 50 && !bvalid; k++) tick();
        cresp = bresp;
        tick();
        bready = 1'b0;
      end
      begin
        rready = 1'b1;
        for (int k = 0; k < 100 && nb < 4; k++) begin
          if (rvalid) begin rd_data[nb] = rdata; nb++; end
          tick();
        end
        rready = 1'b0;
      end
    join
    checks++;
    if (cresp !== 2'b00 || nb != 4) begin errors++; $display("FAIL dual_done: bresp=%b beats=%0d want 00/4", cresp, nb); end
    for (int b = 0; b < nb; b++) begin
      checks++;
      if (rd_data[b] !== model[32 + b]) begin
        errors++; $display("FAIL dual_rbeat%0d: got %h want %h", b, rd_data[b], model[32 + b]);
      end
    end
    model_write(BASE, 8'd3, 3'd3, 2'd1, 4);
    drive_read(BASE, 8'd3, 3'd3, 2'd1, 8'h17, 1'b0, nb, tmo);
    for (int b = 0; b < nb; b++) begin
      checks++;
      if (rd_data[b] !== model[b]) begin errors++; $display("FAIL dual_wmem%0d: got %h want %h", b, rd_data[b], model[b]); end
    end
  endtask

  task automatic test_collision();
    logic [63:0] old, nv; bit tmo; int nb, n;
    old = model[5];
    nv  = {$urandom, $urandom};
    awaddr = BASE + 40; awlen = 0; awsize = 3; awburst = 1; awid = 8'h07; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    wdata = nv; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    bd_we = 1'b1; bd_addr = BASE + 40; bd_wdata = ~nv;
    araddr = BASE + 40; arlen = 0; arsize = 3; arburst = 1; arid = 8'h08; arvalid = 1'b1;
    checks++;
    if ({wready, arready} !== 2'b11) begin errors++; $display("FAIL collide_setup: wready/arready=%b want 11", {wready, arready}); end
    tick();
    wvalid = 1'b0; wlast = 1'b0; bd_we = 1'b0; arvalid = 1'b0;
    checks++;
    if ({rvalid, rdata} !== {1'b1, old}) begin
      errors++; $display("FAIL collide_read_old: rvalid=%b rdata=%h want 1/%h", rvalid, rdata, old);
    end
    rready = 1'b1; tick(); rready = 1'b0;
    bready = 1'b1;
    for (int k = 0; k < 50 && !bvalid; k++) tick();
    tick();
    bready = 1'b0;
    model[5] = nv;
    drive_read(BASE + 40, 8'd0, 3'd3, 2'd1, 8'h09, 1'b0, nb, tmo);
    checks++;
    if (tmo || rd_data[0] !== nv) begin errors++; $display("FAIL collide_w_wins: got %h want %h", rd_data[0], nv); end
  endtask

  task automatic test_reset_mid_burst();
    bit tmo; int nb, n;
    for (int b = 0; b < 8; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    awaddr = BASE; awlen = 7; awsize = 3; awburst = 1; awid = 8'h44; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = 1'b0; wvalid = 1'b1;
      for (int k = 0; k < 50 && !wready; k++) tick();
      tick();
    end
    wvalid = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if ({bvalid, wready, awready} !== 3'b000) begin
      errors++; $display("FAIL midrst_outputs: bvalid/wready/awready=%b want 000", {bvalid, wready, awready});
    end
    rst = 1'b0;
    model_write(BASE, 8'd7, 3'd3, 2'd1, 3);
    tick(); tick();
    drive_read(BASE, 8'd7, 3'd3, 2'd1, 8'h45, 1'b1, nb, tmo);
    checks++;
    if (tmo || nb != 8) begin errors++; $display("FAIL midrst_count: beats=%0d want 8", nb); end
    for (int b = 0; b < nb; b++) begin
      checks++;
      if (rd_data[b] !== model[b]) begin errors++; $display("FAIL midrst_mem%0d: got %h want %h", b, rd_data[b], model[b]); end
    end
  endtask

  task automatic test_mtime();
    logic [1:0] resp; logic [IDW-1:0] gid; bit tmo; int nb;
    logic [63:0] want_data; logic [1:0] want_resp;
`ifdef CLINT_MTIME_EN
    want_data = 64'd12345; want_resp = 2'b00;
`else
    want_data = 64'd0; want_resp = 2'b11;
`endif
    mtime = 64'd12345;
    drive_read(MTIME_A, 8'd0, 3'd3, 2'd1, 8'h55, 1'b0, nb, tmo);
    checks++;
    if (tmo || {rd_data[0], rd_resp[0]} !== {want_data, want_resp}) begin
      errors++; $display("FAIL mtime_read: data=%0d resp=%b want %0d/%b", rd_data[0], rd_resp[0], want_data, want_resp);
    end
    wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
    drive_write(MTIME_A, 8'd0, 3'd3, 2'd1, 8'h56, 1, 0, resp, gid, tmo);
    checks++;
    if (tmo || resp !== want_resp) begin errors++; $display("FAIL mtime_write: bresp=%b want %b", resp, want_resp); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0; mtime = '0;
    test_reset();
    preload();
    test_single_beat();
    test_wrap();
    test_narrow_write();
    test_decerr_backpressure();
    test_random_bursts();
    test_boundary();
    test_wlast_mismatch();
    test_concurrent();
    test_collision();
    test_reset_mid_burst();
    test_mtime();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
